// File: rtl/hcsr04_pkg.sv
// Shared types and default constants for the HC-SR04 distance filter.
package hcsr04_pkg;

    localparam int unsigned DEF_CYC_PER_CM = 5800;
    localparam int unsigned DEF_MIN_CM     = 2;
    localparam int unsigned DEF_MAX_CM     = 400;

    typedef logic [8:0]  dist_t;
    typedef logic [11:0] bcd_t;

    typedef enum logic [2:0] {
        StIdle,
        StDiv,
        StCheck,
        StAvg,
        StBcd,
        StDone
    } hcsr04_state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (double dabble).
// The result appears exactly 9 cycles after start, and bcd only changes on completion.
module bin2bcd_seq
    import hcsr04_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  dist_t bin,
    input  logic  start,
    output bcd_t  bcd,
    output logic  done
);

    // One iteration: add 3 to every nibble >= 5, then shift the next binary bit in.
    function automatic bcd_t dabble_step(bcd_t s, logic b);
        bcd_t adj;
        adj = s;
        for (int k = 0; k < 3; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        return {adj[10:0], b};
    endfunction

    dist_t      shift_q;
    bcd_t       scratch_q;
    bcd_t       bcd_q;
    bcd_t       step_res;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;

    // The start cycle already performs the first iteration on the MSB of bin.
    always_comb begin
        step_res = dabble_step(start ? '0 : scratch_q, start ? bin[8] : shift_q[8]);
    end

    // Iteration state; the visible result is committed only after the ninth step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                scratch_q <= step_res;
                shift_q   <= {bin[7:0], 1'b0};
                cnt_q     <= 4'd1;
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                scratch_q <= step_res;
                shift_q   <= {shift_q[7:0], 1'b0};
                cnt_q     <= cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    busy_q <= 1'b0;
                    bcd_q  <= step_res;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/hcsr04_distance_filter.sv
// Converts HC-SR04 echo widths to centimetres, rejects out-of-range readings,
// smooths accepted readings with a 4-tap moving average and presents binary + BCD.
module hcsr04_distance_filter
    import hcsr04_pkg::*;
#(
    parameter int unsigned CYC_PER_CM = DEF_CYC_PER_CM,
    parameter int unsigned WIDTH_W    = 24,
    parameter int unsigned MIN_CM     = DEF_MIN_CM,
    parameter int unsigned MAX_CM     = DEF_MAX_CM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH_W-1:0] width_i,
    input  logic               width_valid,
    input  logic               timeout_i,
    output logic               ready,
    output dist_t              dist_cm,
    output bcd_t               dist_bcd,
    output logic               out_of_range,
    output logic               dist_valid
);

    localparam int unsigned      CNT_W = $clog2(WIDTH_W + 1);
    localparam logic [WIDTH_W:0] DIV_K = (WIDTH_W + 1)'(CYC_PER_CM);
    localparam logic [WIDTH_W-1:0] MIN_Q = WIDTH_W'(MIN_CM);
    localparam logic [WIDTH_W-1:0] MAX_Q = WIDTH_W'(MAX_CM);

    hcsr04_state_e state_q, state_d;

    // Divider: quo_q starts as the dividend and fills with quotient bits from the right.
    logic [WIDTH_W-1:0] rem_q;
    logic [WIDTH_W-1:0] quo_q;
    logic [CNT_W-1:0]   div_cnt_q;
    logic [WIDTH_W:0]   trial;
    logic               div_last;
    logic               cm_bad;
    dist_t              cm;

    // Moving-average ring buffer.
    dist_t       buf_q [4];
    dist_t       buf_next [4];
    logic [1:0]  wr_ptr_q;
    logic        filled_q;
    logic [10:0] sum;
    dist_t       avg;

    dist_t dist_cm_q;
    logic  oor_q;
    logic  bcd_done;
    logic  accept;

    assign accept   = (state_q == StIdle) && width_valid && !timeout_i;
    assign trial    = {rem_q, quo_q[WIDTH_W-1]};
    assign div_last = (div_cnt_q == CNT_W'(WIDTH_W - 1));
    assign cm_bad   = (quo_q < MIN_Q) || (quo_q > MAX_Q);
    assign cm       = quo_q[8:0];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic; timeout wins over a simultaneous width strobe.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (timeout_i)        state_d = StDone;
                else if (width_valid) state_d = StDiv;
            end
            StDiv:   if (div_last) state_d = StCheck;
            StCheck: state_d = cm_bad ? StDone : StAvg;
            StAvg:   state_d = StBcd;
            StBcd:   if (bcd_done) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Restoring divider, one quotient bit per DIV cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= '0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= width_i;
            div_cnt_q <= '0;
        end else if (state_q == StDiv) begin
            if (trial >= DIV_K) begin
                rem_q <= WIDTH_W'(trial - DIV_K);
                quo_q <= {quo_q[WIDTH_W-2:0], 1'b1};
            end else begin
                rem_q <= trial[WIDTH_W-1:0];
                quo_q <= {quo_q[WIDTH_W-2:0], 1'b0};
            end
            div_cnt_q <= div_cnt_q + CNT_W'(1);
        end
    end

    // Buffer contents after pushing cm; an empty buffer is flooded with the first sample.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            buf_next[i] = (!filled_q || (2'(i) == wr_ptr_q)) ? cm : buf_q[i];
            sum         = sum + 11'(buf_next[i]);
        end
        avg = sum[10:2];
    end

    // Ring buffer, filtered distance and range status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
            wr_ptr_q  <= '0;
            filled_q  <= 1'b0;
            dist_cm_q <= '0;
            oor_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && timeout_i) oor_q <= 1'b1;
            if (state_q == StCheck)             oor_q <= cm_bad;
            if (state_q == StAvg) begin
                for (int i = 0; i < 4; i++) buf_q[i] <= buf_next[i];
                wr_ptr_q  <= wr_ptr_q + 2'd1;
                filled_q  <= 1'b1;
                dist_cm_q <= avg;
            end
        end
    end

    // Conversion starts in AVG on the value being written to dist_cm.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .bin   (avg),
        .start (state_q == StAvg),
        .bcd   (dist_bcd),
        .done  (bcd_done)
    );

    assign ready        = (state_q == StIdle);
    assign dist_valid   = (state_q == StDone);
    assign dist_cm      = dist_cm_q;
    assign out_of_range = oor_q;

endmodule
